// File: rtl/spi_minion_frame_rx.sv
// SPI mode-0 minion: oversamples cs/sclk/mosi on clk, assembles NBITS-bit frames
// into a valid/ready output word and shifts a preloaded response word out on miso.
module spi_minion_frame_rx #(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oeb,
  output logic [NBITS-1:0] recv_msg,
  output logic             recv_val,
  input  logic             recv_rdy,
  input  logic [NBITS-1:0] send_msg,
  input  logic             send_val,
  output logic             send_rdy,
  output logic             overflow,
  output logic             frame_err
);

  localparam int CW = $clog2(NBITS + 2);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state;
  logic             cs_p0, cs_p1, cs_p2;
  logic             sclk_p0, sclk_p1, sclk_p2;
  logic             mosi_p0, mosi_p1, mosi_p3;
  logic             cs_fall_p3, cs_rise_p3, sclk_rise_p3, sclk_fall_p3;
  logic [CW-1:0]    cnt;
  logic [NBITS-1:0] rx_q, tx_q;
  logic [CW-1:0]    cnt_upd;
  logic [NBITS-1:0] rx_upd;
  logic             frame_full;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CW'(NBITS + 1)) ? c : c + 1'b1;
  endfunction

  // p0/p1: two-flop synchronizers; p2: history flop for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_p0   <= 1'b1;
      cs_p1   <= 1'b1;
      cs_p2   <= 1'b1;
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      cs_p0   <= cs;
      cs_p1   <= cs_p0;
      cs_p2   <= cs_p1;
      sclk_p0 <= sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      mosi_p0 <= mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  // p3: registered edge pulses, mosi kept aligned with the sclk edge it belongs to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_fall_p3   <= 1'b0;
      cs_rise_p3   <= 1'b0;
      sclk_rise_p3 <= 1'b0;
      sclk_fall_p3 <= 1'b0;
      mosi_p3      <= 1'b0;
    end else begin
      cs_fall_p3   <= cs_p2 & ~cs_p1;
      cs_rise_p3   <= ~cs_p2 & cs_p1;
      sclk_rise_p3 <= ~sclk_p2 & sclk_p1;
      sclk_fall_p3 <= sclk_p2 & ~sclk_p1;
      mosi_p3      <= mosi_p1;
    end
  end

  // The sclk edge of this cycle is folded in before frame completion is judged,
  // so a final sclk edge coinciding with cs release still counts.
  always_comb begin
    cnt_upd = cnt;
    rx_upd  = rx_q;
    if (state == ACTIVE && sclk_rise_p3) begin
      cnt_upd = sat_inc(cnt);
      rx_upd  = {rx_q[NBITS-2:0], mosi_p3};
    end
    frame_full = (cnt_upd == CW'(NBITS));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      recv_msg  <= '0;
      recv_val  <= 1'b0;
      send_rdy  <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      send_rdy <= 1'b0;
      if (recv_val && recv_rdy) recv_val <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall_p3) begin
            state <= ACTIVE;
            cnt   <= '0;
            rx_q  <= '0;
            if (send_val) begin
              tx_q     <= send_msg;
              send_rdy <= 1'b1;
            end else begin
              tx_q <= '0;
            end
          end
        end
        ACTIVE: begin
          cnt  <= cnt_upd;
          rx_q <= rx_upd;
          if (sclk_fall_p3) tx_q <= {tx_q[NBITS-2:0], 1'b0};
          if (cs_rise_p3) begin
            state <= IDLE;
            if (frame_full) begin
              if (!recv_val || recv_rdy) begin
                recv_msg <= rx_upd;
                recv_val <= 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign miso     = tx_q[NBITS-1];
  assign miso_oeb = cs_p1;

endmodule

// File: tb/tb_spi_minion_frame_rx.sv
// Scoreboard bench for spi_minion_frame_rx: frames are bit-banged on the pads,
// expected words queued by a frame-level model and checked by a separate monitor.
module tb_spi_minion_frame_rx;

  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cs = 1'b1;
  logic          sclk = 1'b0;
  logic          mosi = 1'b0;
  logic          miso, miso_oeb;
  logic [NB-1:0] recv_msg;
  logic          recv_val;
  logic          recv_rdy = 1'b1;
  logic [NB-1:0] send_msg = '0;
  logic          send_val = 1'b0;
  logic          send_rdy, overflow, frame_err;

  spi_minion_frame_rx #(.NBITS(NB)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oeb(miso_oeb),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [NB-1:0] exp_q[$];
  bit            held = 1'b0;
  bit            exp_ovf = 1'b0;
  bit            exp_ferr = 1'b0;
  int            sr_cnt = 0;
  logic [NB-1:0] mon_exp;
  logic [NB-1:0] prev_msg = '0;
  bit            prev_hold = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: consumes a word on every recv handshake, checks hold stability
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        if (send_rdy) sr_cnt++;
        if (recv_val && recv_rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL recv_unexpected actual=%h required=no_transfer", recv_msg);
          end else begin
            mon_exp = exp_q.pop_front();
            check("recv_msg", 64'(recv_msg), 64'(mon_exp));
          end
        end
        if (recv_val && !recv_rdy && prev_hold)
          check("recv_msg_stable", 64'(recv_msg), 64'(prev_msg));
        prev_hold = recv_val && !recv_rdy;
        prev_msg  = recv_msg;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic set_rdy(input bit v);
    @(negedge clk);
    recv_rdy = v;
    if (v) held = 1'b0;
  endtask

  // Frame-level model: decides at cs release what the block must do with the frame
  task automatic model_end(input logic [NB-1:0] d, input int n, input bit raise_rdy,
                           output bit lat_on);
    bit rdy_eff;
    lat_on = 1'b0;
    if (n != NB) begin
      exp_ferr = 1'b1;
    end else begin
      rdy_eff = recv_rdy | raise_rdy;
      if (!held || rdy_eff) begin
        lat_on = !held;
        exp_q.push_back(d);
        held = !rdy_eff;
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  // endmode 0: normal end; 1: last sclk rise together with cs rise; 2: leave frame open
  task automatic run_frame(input logic [NB-1:0] d, input int n, input int endmode,
                           input bit raise_rdy, input bit sv, input logic [NB-1:0] sm);
    logic [NB-1:0] txw, got;
    bit            lat_on;
    int            lat;
    lat_on = 1'b0;
    lat    = 0;
    got    = '0;
    @(negedge clk);
    send_val = sv;
    send_msg = sm;
    sr_cnt   = 0;
    txw      = sv ? sm : '0;
    repeat (2) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    check("miso_oeb_active", 64'(miso_oeb), 64'(0));
    for (int i = 0; i < n; i++) begin
      mosi = d[NB-1-i];
      repeat (4) @(negedge clk);
      got = {got[NB-2:0], miso};
      if (endmode == 1 && i == n - 1) begin
        model_end(d, n, raise_rdy, lat_on);
        cs   = 1'b1;
        sclk = 1'b1;
      end else begin
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
      end
    end
    if (endmode == 0) begin
      repeat (4) @(negedge clk);
      model_end(d, n, raise_rdy, lat_on);
      cs = 1'b1;
    end
    if (endmode != 2) begin
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (raise_rdy && k == 3) recv_rdy = 1'b1;
        if (lat_on && lat == 0 && recv_val) lat = k;
      end
      if (lat_on) check("recv_latency", 64'(lat), 64'(4));
      if (raise_rdy) held = 1'b0;
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      send_val = 1'b0;
      check("miso_bits", 64'(got), 64'(txw >> (NB - n)));
      check("send_rdy_pulses", 64'(sr_cnt), 64'(sv));
      check("overflow", 64'(overflow), 64'(exp_ovf));
      check("frame_err", 64'(frame_err), 64'(exp_ferr));
      check("miso_oeb_idle", 64'(miso_oeb), 64'(1));
    end else begin
      send_val = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_recv_val"}, 64'(recv_val), 64'(0));
    check({tag, "_recv_msg"}, 64'(recv_msg), 64'(0));
    check({tag, "_send_rdy"}, 64'(send_rdy), 64'(0));
    check({tag, "_overflow"}, 64'(overflow), 64'(0));
    check({tag, "_frame_err"}, 64'(frame_err), 64'(0));
    check({tag, "_miso"}, 64'(miso), 64'(0));
    check({tag, "_miso_oeb"}, 64'(miso_oeb), 64'(1));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Basic receive, then response shifting with and without send_val
    run_frame(32'hA5A5_1234, NB, 0, 1'b0, 1'b0, '0);
    run_frame(32'h0F0F_C3C3, NB, 0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    run_frame(32'h1357_9BDF, NB, 0, 1'b0, 1'b0, 32'hFFFF_FFFF);

    for (int r = 0; r < 6; r++)
      run_frame(NB'($urandom), NB, 0, 1'b0, 1'($urandom_range(0, 1)), NB'($urandom));

    // Consume old word and deliver new word in the same cycle
    set_rdy(1'b0);
    run_frame(32'hCAFE_0001, NB, 0, 1'b0, 1'b0, '0);
    run_frame(32'hCAFE_0002, NB, 0, 1'b1, 1'b1, 32'h0123_4567);

    // Short frame is discarded, next frame delivered
    run_frame(32'hFFFF_FFFF, 31, 0, 1'b0, 1'b0, '0);
    run_frame(32'h0000_00FF, NB, 0, 1'b0, 1'b0, '0);

    // Final sclk edge coincides with cs release
    run_frame(32'h6B2D_91E7, NB, 1, 1'b0, 1'b1, 32'h8421_1248);

    // Held word, second frame dropped
    set_rdy(1'b0);
    run_frame(32'h1111_1111, NB, 0, 1'b0, 1'b0, '0);
    run_frame(32'h2222_2222, NB, 0, 1'b0, 1'b0, '0);
    check("held_recv_msg", 64'(recv_msg), 64'(32'h1111_1111));
    check("held_recv_val", 64'(recv_val), 64'(1));
    set_rdy(1'b1);
    repeat (3) @(negedge clk);
    check("drained_recv_val", 64'(recv_val), 64'(0));

    // Reset in the middle of a frame
    run_frame(32'h5555_AAAA, 16, 2, 1'b0, 1'b0, '0);
    @(negedge clk);
    reset = 1'b0;
    cs    = 1'b1;
    sclk  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("midrst");
    reset    = 1'b1;
    held     = 1'b0;
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
    repeat (6) @(negedge clk);
    check("post_reset_recv_val", 64'(recv_val), 64'(0));
    run_frame(32'h8000_0001, NB, 0, 1'b0, 1'b0, '0);

    repeat (20) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
